// File: rtl/yz_seq_detect.sv
// Detects the sampled (y,z) pair sequence 11 -> 01 -> 00, pulses match and keeps a saturating count.
// Optional macro YZ_ERR_DETECT_EN: flags the illegal pair 10 on err and forces the FSM to IDLE.
module yz_seq_detect #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             y,
  input  logic             z,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [1:0]       state_o,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT11 = 2'b01,
    GOT01 = 2'b10
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [3:0]       idle_cnt, idle_cnt_nxt;
  logic             match_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       pair;
  logic             illegal;

  assign pair    = {y, z};
  assign state_o = state;

`ifdef YZ_ERR_DETECT_EN
  assign illegal = in_valid && (pair == 2'b10);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // A valid pair always wins over the timeout; the idle counter only runs while stalled mid-sequence.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    if (illegal) begin
      state_nxt = IDLE;
    end else if (in_valid) begin
      case (state)
        IDLE:    state_nxt = (pair == 2'b11) ? GOT11 : IDLE;
        GOT11: begin
          if (pair == 2'b01)      state_nxt = GOT01;
          else if (pair == 2'b11) state_nxt = GOT11;
          else                    state_nxt = IDLE;
        end
        GOT01:   state_nxt = (pair == 2'b11) ? GOT11 : IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (idle_cnt == TO_LAST) state_nxt = IDLE;
      else                     idle_cnt_nxt = idle_cnt + 4'd1;
    end
  end

  always_comb begin
    match_nxt = in_valid && (state == GOT01) && (pair == 2'b00);
    cnt_nxt   = match_cnt;
    if (match_nxt && (match_cnt != '1)) cnt_nxt = match_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      match     <= match_nxt;
      match_cnt <= cnt_nxt;
      cnt_sat   <= cnt_sat | (cnt_nxt == '1);
    end
  end

`ifdef YZ_ERR_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | illegal;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_yz_seq_detect.sv
// Directed plus random bench for yz_seq_detect against a pair-history reference model.
module tb_yz_seq_detect;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int MAX     = (1 << CNT_W) - 1;
`ifdef YZ_ERR_DETECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             y = 1'b0;
  logic             z = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [1:0]       state_o;
  logic             err;

  int errors = 0;
  int checks = 0;

  // Reference model: last two valid pairs of the current segment plus counts.
  logic [1:0] h1, h2;
  int         n = 0;
  int         idle_run = 0;
  int         mcnt = 0;
  logic       m_match = 1'b0;
  logic       m_err = 1'b0;

  yz_seq_detect #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .y(y), .z(z),
    .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
    .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_state();
    if (n >= 1 && h1 == 2'b11) return 2'b01;
    if (n >= 2 && h2 == 2'b11 && h1 == 2'b01) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("match", 32'(match), 32'(m_match));
    chk("match_cnt", 32'(match_cnt), 32'(mcnt));
    chk("cnt_sat", 32'(cnt_sat), 32'(mcnt == MAX));
    chk("state_o", 32'(state_o), 32'(model_state()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic v, input logic [1:0] p);
    logic [1:0] cur;
    @(negedge clk);
    in_valid = v;
    {y, z}   = p;
    cur      = model_state();
    m_match  = 1'b0;
    if (v) begin
      idle_run = 0;
      if (ERR_EN && p == 2'b10) begin
        m_err = 1'b1;
        n     = 0;
      end else begin
        if (n >= 2 && h2 == 2'b11 && h1 == 2'b01 && p == 2'b00) m_match = 1'b1;
        h2 = h1;
        h1 = p;
        if (n < 2) n++;
      end
    end else if (cur != 2'b00) begin
      idle_run++;
      if (idle_run == TIMEOUT) begin
        n        = 0;
        idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
    if (m_match && mcnt < MAX) mcnt++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset lands while clk is high, away from any edge, to observe the asynchronous clear.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n = 0; idle_run = 0; mcnt = 0; m_match = 1'b0; m_err = 1'b0;
    check_all();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic seq(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    step(1'b1, a);
    step(1'b1, b);
    step(1'b1, c);
  endtask

  initial begin
    h1 = 2'b00;
    h2 = 2'b00;
    async_reset();

    seq(2'b11, 2'b01, 2'b00);
    step(1'b0, 2'b00);

    step(1'b1, 2'b11);
    seq(2'b11, 2'b01, 2'b00);
    async_reset();
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    seq(2'b11, 2'b01, 2'b00);

    step(1'b1, 2'b11);
    repeat (4) step(1'b0, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b00);
    step(1'b1, 2'b11);
    repeat (3) step(1'b0, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b00);

    async_reset();
    repeat (5) seq(2'b11, 2'b01, 2'b00);

    async_reset();
    step(1'b1, 2'b11);
    seq(2'b10, 2'b01, 2'b00);

    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    async_reset();
    step(1'b1, 2'b00);

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [1:0]  p;
      r = $urandom_range(0, 9);
      if (r <= 3)      p = 2'b11;
      else if (r <= 6) p = 2'b01;
      else if (r <= 8) p = 2'b00;
      else             p = 2'b10;
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(2, 6)) step(1'b0, p);
      end else begin
        step(($urandom_range(0, 3) != 0), p);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yz_seq_detect.md
Name: yz_seq_detect

Overview:
- Downstream consumer of the 3-input (a,b,c) -> (y,z) decoder stage.
- Samples the decoder's (y,z) pair on a valid strobe and detects the ordered pair sequence 11 -> 01 -> 00, which corresponds to decoder inputs 110 -> 111 -> 100.
- Reports each detection as a one-cycle pulse and keeps a saturating detection count.
- A timeout returns a partially matched sequence to idle when the decoder stream stalls.

Parameters:
- CNT_W, 8, width of match_cnt.
- TIMEOUT, 4, number of consecutive idle cycles (in_valid=0) in a non-IDLE state before the FSM is forced to IDLE; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  (y,z) is sampled on this clock edge.
- y  input  1  decoder output y.
- z  input  1  decoder output z.
- match  output  1  one-cycle pulse; sequence completed.
- match_cnt  output  CNT_W  count of detections, saturating.
- cnt_sat  output  1  sticky; match_cnt has reached all-ones.
- state_o  output  2  current FSM state (00 IDLE, 01 GOT11, 10 GOT01).
- err  output  1  sticky illegal-pair flag (see Optional Feature).

Behaviour:
- Single clock domain, clk; reset rst_n is asynchronous active-low.
- Reset values: state=IDLE, match=0, match_cnt=0, cnt_sat=0, err=0, idle counter=0.
- Reset asserted mid-sequence aborts immediately with no match pulse.
- Registered outputs:
  - match asserts the cycle after the edge that samples the completing 00 pair, and lasts exactly 1 cycle.
  - match_cnt and cnt_sat update on that same edge as match.
- Pairs are sampled only when in_valid=1. With in_valid=0 the state holds, subject to timeout.
- Transitions (pair written as yz):
  - IDLE: 11 -> GOT11; any other pair -> IDLE.
  - GOT11: 01 -> GOT01; 11 -> GOT11 (overlap); other -> IDLE.
  - GOT01: 00 -> IDLE with match=1; 11 -> GOT11 (overlap restart); other -> IDLE.
- Timeout:
  - The idle counter increments each cycle with in_valid=0 while state!=IDLE.
  - It clears on any in_valid=1 cycle and whenever state=IDLE.
  - When the counter equals TIMEOUT-1 with in_valid=0, the next state is IDLE and the counter clears.
  - A valid pair arriving in the same cycle the timeout would fire takes priority: the pair is evaluated normally.
- match_cnt:
  - Increments by 1 per match.
  - At 2^CNT_W-1 it holds, and cnt_sat sets and stays set until reset.
- No back-pressure; the block accepts a pair every cycle.

Optional Feature:
- Macro: YZ_ERR_DETECT_EN.
- Defined:
  - Pair yz=10 is illegal, because the decoder never drives y=1 with z=0.
  - A valid 10 sets err (sticky until reset) on that edge and forces the FSM to IDLE from any state.
  - Any in-progress partial match is discarded.
- Undefined:
  - err is tied to 0.
  - 10 is treated as an ordinary non-matching pair per the transition rules above.

Test Plan:
- Reset then valid pairs 11,01,00 on 3 consecutive cycles -> match=1 exactly one cycle after the 00 edge; match_cnt=1; state_o sequence 01,10,00.
- Pairs 11,11,01,00 -> single match; match_cnt=1. Then 11,01,11,01,00 -> match once more; match_cnt=2.
- 11, then TIMEOUT=4 idle cycles, then 01,00 -> state_o=00 after the 4th idle cycle; no match. Repeat with 3 idle cycles -> match asserted.
- CNT_W=2, drive 5 complete sequences -> match_cnt goes 1,2,3,3,3; cnt_sat=1 from the 3rd match; match still pulses on the 4th and 5th.
- With YZ_ERR_DETECT_EN: 11,10,01,00 -> err=1 after the 10 edge, state_o=00, no match. Without the macro: the same stream gives no match and err=0.
- Assert rst_n=0 asynchronously between 01 and 00 -> all outputs 0 immediately. Release, then send 00 -> no match.
